// File: rtl/fetch_window_buffer.sv
// fetch_window_buffer
// Circular instruction-word buffer. Fetch appends up to four words per cycle,
// dispatch sees a contiguous window of the oldest WIN words and retires a
// variable number of them per cycle. Window word 0 is always the oldest word.
module fetch_window_buffer #(
  parameter int DEPTH = 32,
  parameter int WIN   = 20,
  parameter int WORD  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [4*WORD-1:0]   in_data,
  input  logic [2:0]          in_count,
  output logic                in_ready,
  output logic [WIN*WORD-1:0] win_data,
  output logic [5:0]          win_count,
  input  logic                consume_valid,
  input  logic [4:0]          consume_len,
  input  logic                flush,
  output logic                overrun_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] WIN_W   = (AW+1)'(WIN);
  localparam logic [AW:0] LINE_W  = (AW+1)'(4);

  // Storage holds no reset; only the bookkeeping below is reset.
  logic [WORD-1:0] mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [AW:0]     occ;
  logic [AW:0]     occ_win;
  logic [AW:0]     push_cnt;
  logic [AW:0]     consume_ext;
  logic [AW:0]     eff;
  logic            overrun_now;

  // Ready depends only on registered occupancy, so a line is accepted only
  // when a full four-word line is guaranteed to fit.
  assign in_ready    = (DEPTH_W - occ) >= LINE_W;
  assign occ_win     = (occ >= WIN_W) ? WIN_W : occ;
  assign win_count   = 6'(occ_win);
  assign consume_ext = (AW+1)'(consume_len);

  // Number of words actually appended this cycle (zero when not accepted,
  // when flushing, or when fetch claims zero words; oversized counts clamp).
  always_comb begin
    push_cnt = '0;
    if (in_valid && in_ready && !flush) begin
      if (in_count > 3'd4) begin
        push_cnt = LINE_W;
      end else begin
        push_cnt = (AW+1)'(in_count);
      end
    end
  end

  // Consumption is limited to what the window actually shows; asking for
  // more than that is flagged as an overrun instead of eating stale words.
  always_comb begin
    eff         = '0;
    overrun_now = 1'b0;
    if (consume_valid && !flush) begin
      if (consume_ext > occ_win) begin
        eff         = occ_win;
        overrun_now = 1'b1;
      end else begin
        eff = consume_ext;
      end
    end
  end

  // Pointer, occupancy and sticky error update; flush wipes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      occ         <= '0;
      overrun_err <= 1'b0;
    end else if (flush) begin
      head        <= '0;
      tail        <= '0;
      occ         <= '0;
      overrun_err <= 1'b0;
    end else begin
      head <= head + eff[AW-1:0];
      tail <= tail + push_cnt[AW-1:0];
      occ  <= occ + push_cnt - eff;
      if (overrun_now) begin
        overrun_err <= 1'b1;
      end
    end
  end

  // Append the accepted words at the tail, wrapping modulo DEPTH.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if ((AW+1)'(k) < push_cnt) begin
        mem[tail + AW'(k)] <= in_data[k*WORD +: WORD];
      end
    end
  end

  // Window read: oldest word first, zero beyond the valid count.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < WIN; i++) begin
      if ((AW+1)'(i) < occ_win) begin
        win_data[i*WORD +: WORD] = mem[head + AW'(i)];
      end
    end
  end

endmodule

// File: doc/fetch_window_buffer.md
# fetch_window_buffer

Circular instruction-word buffer that feeds the dispatcher with the contiguous 64-bit instruction-word window it slices into up to four variable-length instructions. Fetch writes up to four words per cycle. Dispatch reports the total words it consumed, the sum of its four instruction lengths. The buffer advances its head by that amount and presents the next window starting at word 0.

## Interface
- DEPTH, 32: buffer capacity in 64-bit words; power of two, ≥ WIN+4.
- WIN, 20: window width in words presented to dispatch.
- WORD, 64: instruction word width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset; single clock domain.
- in_valid  in  1  fetch offers a line this cycle.
- in_data  in  4*WORD  fetch line; word k in bits [k*WORD +: WORD], word 0 oldest.
- in_count  in  3  valid words in in_data, 1..4; words ≥ in_count ignored.
- in_ready  out  1  buffer accepts a line this cycle.
- win_data  out  WIN*WORD  window; word i = i-th oldest buffered word; zero where i ≥ win_count.
- win_count  out  6  valid words in window = min(occupancy, WIN).
- consume_valid  in  1  dispatch consumed words this cycle.
- consume_len  in  5  words consumed, 0..16.
- flush  in  1  synchronous discard of all buffered words (redirect).
- overrun_err  out  1  sticky: consume_len exceeded win_count.

## Operation
- State: storage array mem[DEPTH], head and tail pointers (log2 DEPTH bits, wrap modulo DEPTH), occupancy count (log2 DEPTH + 1 bits), sticky overrun_err.
- Push: fires when in_valid && in_ready. Writes in_data words 0..in_count-1 to mem[(tail+k) mod DEPTH]. tail += in_count. An in_count of 0 is treated as no push. Values 5..7 are clamped to 4.
- in_ready = (DEPTH − occupancy) ≥ 4. It depends on registered occupancy only, never on same-cycle consume.
- Consume: fires when consume_valid. Effective length eff = min(consume_len, win_count). head += eff.
  - If consume_len > win_count, overrun_err sets and stays set until reset or flush.
  - consume_len = 0 is legal and does nothing.
- Simultaneous push and consume: both apply. occupancy_next = occupancy + pushed − eff. Written words never overlap consumed words, because in_ready guarantees free space.
- Flush: has priority over push and consume in the same cycle. head = tail = 0, occupancy = 0, overrun_err = 0. The incoming line is dropped.
- Window: combinational read. win_data word i = mem[(head+i) mod DEPTH] when i < win_count, otherwise 0. Wrap across index DEPTH−1 → 0 is seamless.
- Memory contents need no reset. Only pointers, count and error are reset.

## Timing
- Reset (rst_n low, asynchronous):
  - head = tail = occupancy = 0.
  - overrun_err = 0, in_ready = 1.
  - win_count = 0, win_data = all zero.
- Push-to-window latency: 1 cycle. Words pushed at edge N appear in win_data/win_count after edge N.
- Consume-to-advance latency: 1 cycle. After the edge, win_data word 0 is the first unconsumed word.
- Full: in_ready = 0 when fewer than 4 words are free. A line offered while not ready is not taken, and fetch must hold it.
- Empty: win_count = 0 and win_data = 0. Any nonzero consume sets overrun_err and head does not move.
- rst_n asserted mid-operation: everything returns to reset values immediately. In-flight lines and consumes are lost.

## Test plan
- Reset then push 4 lines of 4 words (values 1..16), no consume. Required: win_count = 16, word i = i+1, words 16..19 zero, in_ready = 1.
- Fill to 29 words, then offer a line. Required:
  - in_ready = 0 and nothing is accepted.
  - consume_len = 5 in the same cycle → next cycle occupancy 24, in_ready = 1.
- Wrap-around: cycle pushes of 3 and consumes of 3 for 40 cycles with an incrementing pattern. Required: window word 0 always equals the next expected value, and the window is contiguous across the DEPTH boundary.
- Simultaneous push (in_count = 2) and consume_len = 7 with occupancy 10. Required: next occupancy 5, window word 0 = old word 7.
- Overconsume: occupancy 3, consume_len = 9. Required: head advances 3, win_count = 0, overrun_err = 1 and holds. Then flush → overrun_err = 0.
- Flush with a concurrent valid push and consume. Required: next cycle win_count = 0, pushed line discarded, in_ready = 1.
